// File: rtl/disp_pkg.sv
// Shared constants for the display source arbiter: source indices, FSM state
// encoding, BCD blank code and a small one-hot helper.
package disp_pkg;

  localparam int SRC_CLK  = 0;
  localparam int SRC_SW   = 1;
  localparam int SRC_EDIT = 2;
  localparam int SRC_ALM  = 3;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_DEF    = 2'd0,
    ST_OWN    = 2'd1,
    ST_LINGER = 2'd2,
    ST_PEND   = 2'd3
  } arb_state_t;

  // Sources strictly above a one-hot owner, i.e. those allowed to preempt it.
  function automatic logic [3:0] above_mask(input logic [3:0] onehot);
    logic [3:0] at_or_below;
    at_or_below = {onehot[2:0], 1'b0} - 4'd1;
    return ~at_or_below;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Fixed-priority encoder, one-hot winner: alarm > edit > stopwatch > clock.
module prio_enc4
  import disp_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] win
);

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    win = '0;
    if      (req[SRC_ALM])  win[SRC_ALM]  = 1'b1;
    else if (req[SRC_EDIT]) win[SRC_EDIT] = 1'b1;
    else if (req[SRC_SW])   win[SRC_SW]   = 1'b1;
    else if (req[SRC_CLK])  win[SRC_CLK]  = 1'b1;
  end

endmodule

// File: rtl/disp_source_arbiter.sv
// Chooses which time source owns the 7-seg display; switches only on frame_sync.
// Optional DISP_ARB_BLANK_EN blanks the tubes for one frame after each switch.
module disp_source_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 200_000_000,
  parameter int unsigned SRC_N    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_sync,
  input  logic [SRC_N-1:0]       req,
  input  logic [SRC_N-1:0][23:0] src_data,
  input  logic [SRC_N-1:0][5:0]  src_blink,
  input  logic [SRC_N-1:0]       src_mode,
  output logic [SRC_N-1:0]       grant,
  output logic [23:0]            disp_data,
  output logic [5:0]             disp_blink,
  output logic                   disp_mode,
  output logic                   disp_blank
);

  localparam int unsigned     CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             low_q;
  logic [3:0]       eff_req;
  logic [3:0]       cand;
  logic [3:0]       winner;
  logic             owner_req;
  logic             expired;
  logic             hold;
  logic             switch_now;
  logic [23:0]      sel_data;
  logic [5:0]       sel_blink;
  logic             sel_mode;

  // While the owner still holds (requesting or lingering), only higher sources
  // compete with it; once the linger expires every requester, plus clock, does.
  always_comb begin
    eff_req          = req;
    eff_req[SRC_CLK] = 1'b1;
    owner_req        = |(eff_req & grant);
    expired          = (state == ST_LINGER || state == ST_PEND) && low_q &&
                       (cnt == CNT_LAST);
    hold             = owner_req || !expired;
    cand             = hold ? ((eff_req & above_mask(grant)) | grant) : eff_req;
  end

  prio_enc4 u_prio (
    .req (cand),
    .win (winner)
  );

  assign switch_now = frame_sync && (winner != grant);

  always_comb begin
    sel_data  = '0;
    sel_blink = '0;
    sel_mode  = 1'b0;
    for (int i = 0; i < int'(SRC_N); i++) begin
      if (grant[i]) begin
        sel_data  = sel_data  | src_data[i];
        sel_blink = sel_blink | src_blink[i];
        sel_mode  = sel_mode  | src_mode[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_DEF;
      grant      <= SRC_N'(1);
      cnt        <= '0;
      low_q      <= 1'b0;
      disp_data  <= 24'h000000;
      disp_blink <= '0;
      disp_mode  <= 1'b1;
    end else begin
      disp_data  <= sel_data;
      disp_blink <= sel_blink;
      disp_mode  <= sel_mode;

      if (winner == grant) begin
        state <= grant[SRC_CLK] ? ST_DEF : (owner_req ? ST_OWN : ST_LINGER);
      end else if (frame_sync) begin
        grant <= winner;
        state <= winner[SRC_CLK] ? ST_DEF : ST_OWN;
      end else begin
        state <= ST_PEND;
      end

      // First low cycle only arms the linger; counting starts the cycle after.
      if (switch_now || owner_req) begin
        cnt   <= '0;
        low_q <= 1'b0;
      end else begin
        low_q <= 1'b1;
        if (low_q && cnt != CNT_LAST) cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DISP_ARB_BLANK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_blank <= 1'b0;
    end else if (switch_now) begin
      disp_blank <= 1'b1;
    end else if (frame_sync) begin
      disp_blank <= 1'b0;
    end
  end
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Self-checking bench for disp_source_arbiter: directed table, hand sequences
// for linger/reset corners, then random traffic against a behavioural model.
module tb_disp_source_arbiter;

  localparam int HOLD = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_sync;
  logic [3:0]       req;
  logic [3:0][23:0] src_data;
  logic [3:0][5:0]  src_blink;
  logic [3:0]       src_mode;
  logic [3:0]       grant;
  logic [23:0]      disp_data;
  logic [5:0]       disp_blink;
  logic             disp_mode;
  logic             disp_blank;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index and length of the owner's current idle run.
  int          m_own;
  int          m_low;
  logic [23:0] m_data;
  logic [5:0]  m_blink;
  logic        m_mode;
  logic        m_blank;

  typedef struct {
    logic [3:0] req;
    logic       fs;
    logic [3:0] grant;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  disp_source_arbiter #(.HOLD_CYC(HOLD), .SRC_N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .req        (req),
    .src_data   (src_data),
    .src_blink  (src_blink),
    .src_mode   (src_mode),
    .grant      (grant),
    .disp_data  (disp_data),
    .disp_blink (disp_blink),
    .disp_mode  (disp_mode),
    .disp_blank (disp_blank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own   = 0;
    m_low   = 0;
    m_data  = 24'h000000;
    m_blink = 6'h00;
    m_mode  = 1'b1;
    m_blank = 1'b0;
  endtask

  // One clock of the display-ownership rules, evaluated on the sampled inputs.
  task automatic model_update();
    int low_now;
    bit retained;
    int desired;
    m_data  = src_data[m_own];
    m_blink = src_blink[m_own];
    m_mode  = src_mode[m_own];
    if (m_own == 0 || req[m_own]) low_now = 0;
    else                          low_now = (m_low > HOLD) ? m_low : m_low + 1;
    retained = (m_own == 0) || (low_now <= HOLD);
    desired  = m_own;
    for (int s = 0; s < 4; s++)
      if ((s == 0 || req[s]) && (s > m_own || !retained)) desired = s;
    if (frame_sync && desired != m_own) begin
      m_own = desired;
      m_low = 0;
`ifdef DISP_ARB_BLANK_EN
      m_blank = 1'b1;
`endif
    end else begin
      m_low = low_now;
      if (frame_sync) m_blank = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("grant",      grant,      32'd1 << m_own);
    check("disp_data",  disp_data,  m_data);
    check("disp_blink", disp_blink, m_blink);
    check("disp_mode",  disp_mode,  m_mode);
    check("disp_blank", disp_blank, m_blank);
  endtask

  // Called at a negedge: drive, let one posedge pass, compare at next negedge.
  task automatic cycle(input logic [3:0] r, input logic fs);
    req        = r;
    frame_sync = fs;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_grant", grant,      4'b0001);
    check("rst_data",  disp_data,  24'h000000);
    check("rst_blink", disp_blink, 6'h00);
    check("rst_mode",  disp_mode,  1'b1);
    check("rst_blank", disp_blank, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 1'b0, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0001};
    tbl[2]  = '{4'b0010, 1'b0, 4'b0001};
    tbl[3]  = '{4'b0010, 1'b0, 4'b0001};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0010};
    tbl[5]  = '{4'b0010, 1'b0, 4'b0010};
    tbl[6]  = '{4'b0110, 1'b0, 4'b0010};
    tbl[7]  = '{4'b0110, 1'b1, 4'b0100};
    tbl[8]  = '{4'b0100, 1'b0, 4'b0100};
    tbl[9]  = '{4'b0110, 1'b1, 4'b0100};
    tbl[10] = '{4'b0100, 1'b1, 4'b0100};
    tbl[11] = '{4'b1100, 1'b0, 4'b0100};
    tbl[12] = '{4'b0100, 1'b1, 4'b0100};
    tbl[13] = '{4'b0100, 1'b0, 4'b0100};
    tbl[14] = '{4'b1100, 1'b1, 4'b1000};
    tbl[15] = '{4'b1100, 1'b0, 4'b1000};

    rst          = 1'b0;
    req          = 4'b0000;
    frame_sync   = 1'b0;
    src_data[0]  = 24'h123456;
    src_data[1]  = 24'h000100;
    src_data[2]  = 24'h235959;
    src_data[3]  = 24'h070000;
    src_blink[0] = 6'b000000;
    src_blink[1] = 6'b000011;
    src_blink[2] = 6'b110000;
    src_blink[3] = 6'b111111;
    src_mode     = 4'b1011;
    model_reset();

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].req, tbl[i].fs);
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
      if (i == 0) check("first_data", disp_data, 24'h123456);
    end

    // Reset while alarm owns the display.
    do_reset();

    // Edit lingers exactly HOLD cycles with frame_sync present every cycle.
    cycle(4'b0100, 1'b1);
    check("edit_grant", grant, 4'b0100);
    for (int k = 0; k < HOLD; k++) begin
      cycle(4'b0000, 1'b1);
      check($sformatf("linger%0d", k), grant, 4'b0100);
    end
    cycle(4'b0000, 1'b1);
    check("linger_expire", grant, 4'b0001);

    // Re-assert during linger keeps edit; expiry without frame_sync waits.
    cycle(4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) cycle(4'b0000, 1'b0);
    for (int k = 0; k < 12; k++) cycle(4'b0100, (k % 3) == 0);
    check("reassert_grant", grant, 4'b0100);
    for (int k = 0; k < 12; k++) cycle(4'b0000, 1'b0);
    check("expired_no_fs", grant, 4'b0100);
    cycle(4'b0000, 1'b1);
    check("expired_fs", grant, 4'b0001);

    // Reset aborts a pending switch; it completes only on a later frame_sync.
    cycle(4'b0010, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(4'b0010, 1'b0);
    check("post_rst_hold", grant, 4'b0001);
    cycle(4'b0010, 1'b1);
    check("post_rst_switch", grant, 4'b0010);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 63) == 0) begin
        for (int s = 0; s < 4; s++) begin
          src_data[s]  = 24'($urandom());
          src_blink[s] = 6'($urandom());
          src_mode[s]  = 1'($urandom());
        end
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle(r, $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
